// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// The mode encoding matches the mealy_in control bit.
package seq_det_pkg;

  typedef enum logic {
    MODE_MOORE = 1'b0,
    MODE_MEALY = 1'b1
  } mode_e;

  localparam int unsigned PAT_W_MAX = 32;

  // Width needed to hold a fill count of 0..pat_w.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Control/status bundle for seq_pattern_detector.
// The master side drives the serial stream and config; the slave side is the detector.
interface seq_pattern_detector_if
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) ();

  localparam int unsigned FILL_W = fill_width(PAT_W);

  logic              en;
  logic              x;
  logic              load;
  logic [PAT_W-1:0]  pattern_in;
  logic              overlap_in;
  logic              mealy_in;
  logic              cnt_clr;
  logic              Y;
  logic [CNT_W-1:0]  match_cnt;
  logic [FILL_W-1:0] fill;

  modport master (
    output en, x, load, pattern_in, overlap_in, mealy_in, cnt_clr,
    input  Y, match_cnt, fill
  );

  modport slave (
    input  en, x, load, pattern_in, overlap_in, mealy_in, cnt_clr,
    output Y, match_cnt, fill
  );

endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial detector for a runtime-loaded PAT_W-bit pattern with Mealy/Moore output,
// optional overlapping matches and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_pattern_detector_if.slave bus
);

  localparam int unsigned FILL_W = fill_width(PAT_W);

  logic [PAT_W-1:0]  r_pat;
  logic              r_ovl;
  mode_e             r_mode;
  // Only PAT_W-1 history bits are stored; the newest bit comes straight from x.
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_y;

  logic [PAT_W-1:0]  w_cand;
  logic              w_step;
  logic              w_full;
  logic              w_hit;

  assign w_cand = {r_hist, bus.x};
  assign w_step = bus.en & ~bus.load;
  // Blocks false matches against zero history after reset or load.
  assign w_full = (r_fill >= FILL_W'(PAT_W - 1));
  assign w_hit  = w_step & w_full & (w_cand == r_pat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat  <= '0;
      r_ovl  <= 1'b0;
      r_mode <= MODE_MEALY;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (bus.load) begin
      r_pat  <= bus.pattern_in;
      r_ovl  <= bus.overlap_in;
      r_mode <= mode_e'(bus.mealy_in);
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else begin
      r_y <= w_hit;
      if (bus.en) begin
        r_hist <= w_cand[PAT_W-2:0];
        if (w_hit && !r_ovl) begin
          r_fill <= '0;
        end else if (r_fill != FILL_W'(PAT_W)) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (w_hit),
    .q     (bus.match_cnt)
  );

  assign bus.Y    = (r_mode == MODE_MEALY) ? w_hit : r_y;
  assign bus.fill = r_fill;

endmodule
